// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit : load-use stall, branch flush and counted HLT drain controller
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int               REG_W              = 4,
  parameter int               OPC_W              = 4,
  parameter logic [OPC_W-1:0] HLT_OPCODE         = 4'hF,
  parameter int               LOAD_USE_CYCLES    = 1,
  parameter int               FLUSH_CYCLES       = 2,
  parameter int               HLT_DRAIN          = 3,
  parameter int               ZERO_REG_HARDWIRED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [OPC_W-1:0] if_id_opcode,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rs,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_dst,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             halt_pending,
  output logic             hlt_out
);

  localparam int LU_W = $clog2(LOAD_USE_CYCLES + 1);
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int HL_W = $clog2(HLT_DRAIN + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [LU_W-1:0] lu_cnt;
  logic [FL_W-1:0] fl_cnt;
  logic [HL_W-1:0] hl_cnt;

  logic lu_hit;
  logic flush_req;
  logic lu_stall;
  logic hlt_accept;

  always_comb begin
    lu_hit = if_id_valid && id_ex_memread &&
             ((if_id_uses_rs && (if_id_rs == id_ex_dst)) ||
              (if_id_uses_rt && (if_id_rt == id_ex_dst)));
    if ((ZERO_REG_HARDWIRED != 0) && (id_ex_dst == '0)) begin
      lu_hit = 1'b0;
    end
    flush_req  = (state != HALTED) && (ex_branch_taken || (fl_cnt != '0));
    lu_stall   = (state == RUN) && !flush_req && (lu_hit || (lu_cnt != '0));
    hlt_accept = (state == RUN) && if_id_valid && (if_id_opcode == HLT_OPCODE) &&
                 !lu_stall && !flush_req;

    stall        = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    halt_pending = 1'b0;
    hlt_out      = 1'b0;
    if (!rst) begin
      stall        = lu_stall || (state != RUN);
      bubble       = lu_stall || (state != RUN);
      flush        = flush_req;
      halt_pending = (state == DRAIN);
      hlt_out      = (state == HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= '0;
      fl_cnt <= '0;
      hl_cnt <= '0;
    end else begin
      if (state == HALTED) begin
        fl_cnt <= '0;
      end else if (ex_branch_taken) begin
        fl_cnt <= FL_W'(FLUSH_CYCLES - 1);
      end else if (fl_cnt != '0) begin
        fl_cnt <= fl_cnt - FL_W'(1);
      end

      if ((state != RUN) || flush_req) begin
        lu_cnt <= '0;
      end else if (lu_cnt != '0) begin
        lu_cnt <= lu_cnt - LU_W'(1);
      end else if (lu_hit) begin
        lu_cnt <= LU_W'(LOAD_USE_CYCLES - 1);
      end

      // The acceptance edge already counts as the first drain cycle, so hlt_out
      // rises exactly HLT_DRAIN cycles after the HLT was seen.
      case (state)
        RUN: begin
          if (hlt_accept) begin
            if (HLT_DRAIN <= 1) begin
              state  <= HALTED;
              hl_cnt <= '0;
            end else begin
              state  <= DRAIN;
              hl_cnt <= HL_W'(HLT_DRAIN - 1);
            end
          end
        end
        DRAIN: begin
          if (ex_branch_taken) begin
            state  <= RUN;
            hl_cnt <= '0;
          end else if (hl_cnt <= HL_W'(1)) begin
            state  <= HALTED;
            hl_cnt <= '0;
          end else begin
            hl_cnt <= hl_cnt - HL_W'(1);
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state  <= RUN;
          hl_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_unit : randomized check of three hazard_unit configurations
// Revision       : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_id_valid;
  logic [3:0] if_id_opcode;
  logic [3:0] if_id_rs;
  logic [3:0] if_id_rt;
  logic       if_id_uses_rs;
  logic       if_id_uses_rt;
  logic       id_ex_memread;
  logic [3:0] id_ex_dst;
  logic       ex_branch_taken;

  logic [2:0] stall_v;
  logic [2:0] bubble_v;
  logic [2:0] flush_v;
  logic [2:0] hp_v;
  logic [2:0] hlt_v;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-instance configuration: {LOAD_USE, FLUSH, HLT_DRAIN, ZERO_REG}
  int p_lu[3] = '{2, 7, 1};
  int p_fl[3] = '{2, 7, 1};
  int p_hl[3] = '{3, 15, 1};
  int p_zr[3] = '{1, 1, 0};

  // Model keeps event timestamps rather than counters
  int last_br[3];
  int lu_start[3];
  int acc[3];

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_USE_CYCLES(2), .FLUSH_CYCLES(2), .HLT_DRAIN(3), .ZERO_REG_HARDWIRED(1)) u_dut0 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(if_id_uses_rs),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_dst(id_ex_dst),
    .ex_branch_taken(ex_branch_taken), .stall(stall_v[0]), .bubble(bubble_v[0]),
    .flush(flush_v[0]), .halt_pending(hp_v[0]), .hlt_out(hlt_v[0]));

  hazard_unit #(.LOAD_USE_CYCLES(7), .FLUSH_CYCLES(7), .HLT_DRAIN(15), .ZERO_REG_HARDWIRED(1)) u_dut1 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(if_id_uses_rs),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_dst(id_ex_dst),
    .ex_branch_taken(ex_branch_taken), .stall(stall_v[1]), .bubble(bubble_v[1]),
    .flush(flush_v[1]), .halt_pending(hp_v[1]), .hlt_out(hlt_v[1]));

  hazard_unit #(.LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .HLT_DRAIN(1), .ZERO_REG_HARDWIRED(0)) u_dut2 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(if_id_uses_rs),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_dst(id_ex_dst),
    .ex_branch_taken(ex_branch_taken), .stall(stall_v[2]), .bubble(bubble_v[2]),
    .flush(flush_v[2]), .halt_pending(hp_v[2]), .hlt_out(hlt_v[2]));

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Evaluates one cycle of instance k against the current inputs, then advances
  // the model as the coming rising edge would.
  task automatic model_cycle(input int k);
    bit halted, drain, hit, fl, lubusy, lus;
    int age;
    if (rst) begin
      check($sformatf("rst_stall%0d", k), stall_v[k], 1'b0);
      check($sformatf("rst_bubble%0d", k), bubble_v[k], 1'b0);
      check($sformatf("rst_flush%0d", k), flush_v[k], 1'b0);
      check($sformatf("rst_hp%0d", k), hp_v[k], 1'b0);
      check($sformatf("rst_hlt%0d", k), hlt_v[k], 1'b0);
      last_br[k]  = -1000;
      lu_start[k] = -1000;
      acc[k]      = -1;
      return;
    end
    age    = cyc - acc[k];
    halted = (acc[k] >= 0) && (age >= p_hl[k]);
    drain  = (acc[k] >= 0) && (age >= 1) && (age < p_hl[k]);
    hit    = if_id_valid && id_ex_memread &&
             ((if_id_uses_rs && (if_id_rs == id_ex_dst)) || (if_id_uses_rt && (if_id_rt == id_ex_dst))) &&
             !((p_zr[k] != 0) && (id_ex_dst == 4'd0));
    fl     = !halted && (ex_branch_taken ||
             ((cyc - last_br[k] >= 1) && (cyc - last_br[k] < p_fl[k])));
    lubusy = (cyc - lu_start[k] >= 1) && (cyc - lu_start[k] < p_lu[k]);
    lus    = !halted && !drain && !fl && (lubusy || hit);

    check($sformatf("stall%0d", k), stall_v[k], lus || drain || halted);
    check($sformatf("bubble%0d", k), bubble_v[k], lus || drain || halted);
    check($sformatf("flush%0d", k), flush_v[k], fl);
    check($sformatf("halt_pending%0d", k), hp_v[k], drain);
    check($sformatf("hlt_out%0d", k), hlt_v[k], halted);

    if (!halted && !drain && if_id_valid && (if_id_opcode == 4'hF) && !lus && !fl) acc[k] = cyc;
    if (drain && ex_branch_taken) acc[k] = -1;
    if (fl) lu_start[k] = -1000;
    else if (lus && !lubusy) lu_start[k] = cyc;
    if (ex_branch_taken && !halted) last_br[k] = cyc;
  endtask

  task automatic eval_all();
    #1;
    for (int k = 0; k < 3; k++) model_cycle(k);
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      last_br[k]  = -1000;
      lu_start[k] = -1000;
      acc[k]      = -1;
    end

    // Reset with every input active, including a HLT and a live hazard
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; if_id_valid = 1'b1; if_id_opcode = 4'hF; if_id_rs = 4'd3; if_id_rt = 4'd3;
      if_id_uses_rs = 1'b1; if_id_uses_rt = 1'b1; id_ex_memread = 1'b1; id_ex_dst = 4'd3;
      ex_branch_taken = 1'b1;
      eval_all();
    end

    for (int i = 0; i < 6000; i++) begin
      bit quiet;
      quiet = ((i / 300) % 2) == 1;
      @(negedge clk);
      rst             = ($urandom_range(0, 79) == 0);
      if_id_valid     = ($urandom_range(0, 3) != 0);
      if_id_opcode    = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if_id_rs        = 4'($urandom_range(0, 3));
      if_id_rt        = 4'($urandom_range(0, 3));
      if_id_uses_rs   = 1'($urandom_range(0, 1));
      if_id_uses_rt   = 1'($urandom_range(0, 1));
      id_ex_memread   = (quiet ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1));
      id_ex_dst       = 4'($urandom_range(0, 3));
      ex_branch_taken = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
      eval_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
